fifo_burst_reader: RTL and testbench

Read-side engine for the team's 16-entry byte FIFO. A start pulse loads a burst length. The block then drains that many bytes from the FIFO read port and presents them on a valid/ready output stream to the downstream consumer. Flow control follows the FIFO's registered read: data appears one cycle after an accepted r_en. A 2-entry output buffer absorbs that in-flight data under backpressure.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/stream_buf2.sv | 51 +++++
 rtl/fifo_burst_reader.sv | 101 ++++++++++
 tb/tb_fifo_burst_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO burst reader.
package fifo_rd_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready skid buffer; head is entry 0, simultaneous push and pop allowed.
module stream_buf2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        slot;

  // Pop shifts entry 1 forward; a push lands in the first free slot after that shift.
  always_comb begin
    mem_d = mem_q;
    slot  = occ_q - 2'(pop_i);
    if (pop_i) begin
      mem_d[0] = mem_q[1];
    end
    if (push_i) begin
      mem_d[slot[0]] = push_data_i;
    end
    occ_d = slot + 2'(push_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      occ_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[0];
  assign occ_o  = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && occ_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && occ_q == 2'd0));

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a requested number of bytes from a registered-read FIFO onto a valid/ready stream.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  output logic              fifo_r_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic [LEN_W-1:0]  count_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             inflight_q;
  logic             pop;
  logic             rd_en;
  logic [1:0]       occ;
  logic [2:0]       level;

  stream_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .head_o      (m_data_o),
    .occ_o       (occ)
  );

  assign m_valid_o = (occ != 2'd0);
  assign pop       = m_valid_o & m_ready_i;

  // Only issue a read if its data will have a free buffer slot when it returns.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    count_d  = count_q;
    level    = 3'(occ) + 3'(inflight_q) - 3'(pop);
    rd_en    = (state_q == RUN) && (issued_q < len_q) && !fifo_empty_i &&
               (level < 3'd2) && !rst;
    if (rd_en) begin
      issued_d = issued_q + LEN_W'(1);
    end
    if (pop) begin
      count_d = count_q + LEN_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d    = len_i;
          issued_d = '0;
          count_d  = '0;
          state_d  = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (pop && (count_q + LEN_W'(1) == len_q)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
    end
  end

  assign fifo_r_en_o = rd_en;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign count_o     = count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural registered-read FIFO.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy, done;
  logic          fifo_empty, fifo_r_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic [LW-1:0] count;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_empty_i (fifo_empty),
    .fifo_r_en_o  (fifo_r_en),
    .fifo_data_i  (fifo_data),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready),
    .count_o      (count)
  );

  // FIFO model: writer owns wr_ptr/mem, read port owns rd_ptr/fifo_data.
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  int cyc = 0;
  int rd_cyc[$], hs_cyc[$], hs_dat[$], done_cyc[$];
  int rd0, hs0, dn0;
  int checks = 0, errors = 0;
  int e0;

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[8'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
      rd_cyc.push_back(cyc);
    end
    if (!rst && m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      hs_dat.push_back(int'(m_data));
    end
    if (!rst && done) done_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  typedef struct {
    int         len;
    int         npre;
    logic [7:0] rpat;
    int         exp_count;
    int         exp_left;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int nrd();  return rd_cyc.size() - rd0;   endfunction
  function automatic int nhs();  return hs_cyc.size() - hs0;   endfunction
  function automatic int ndn();  return done_cyc.size() - dn0; endfunction
  function automatic int rd_at(input int i);
    return (rd0 + i < rd_cyc.size()) ? rd_cyc[rd0 + i] : -1;
  endfunction
  function automatic int hsc_at(input int i);
    return (hs0 + i < hs_cyc.size()) ? hs_cyc[hs0 + i] : -1;
  endfunction
  function automatic int hsd_at(input int i);
    return (hs0 + i < hs_dat.size()) ? hs_dat[hs0 + i] : -1;
  endfunction
  function automatic int dn_at(input int i);
    return (dn0 + i < done_cyc.size()) ? done_cyc[dn0 + i] : -1;
  endfunction

  task automatic clear_log();
    rd0 = rd_cyc.size();
    hs0 = hs_cyc.size();
    dn0 = done_cyc.size();
  endtask

  task automatic preload(input int n, input int base, input int step);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mem[8'(wr_ptr)] = 8'(base + i * step);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic do_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = LW'(l);
    @(negedge clk);
    start = 1'b0;
    e0    = cyc - 1;
  endtask

  task automatic wait_done(input string nm, input bit use_pat, input logic [7:0] pat);
    int n;
    n = 0;
    while (ndn() == 0 && n < 300) begin
      if (use_pat) m_ready = pat[cyc % 8];
      @(negedge clk);
      n++;
    end
    chk({nm, " done_seen"}, (ndn() != 0) ? 1 : 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic stable;

    vecs[0] = '{len: 1, npre: 1, rpat: 8'hFF, exp_count: 1, exp_left: 0};
    vecs[1] = '{len: 3, npre: 5, rpat: 8'hAA, exp_count: 3, exp_left: 2};
    vecs[2] = '{len: 6, npre: 6, rpat: 8'h33, exp_count: 6, exp_left: 0};
    vecs[3] = '{len: 2, npre: 2, rpat: 8'h01, exp_count: 2, exp_left: 0};
    vecs[4] = '{len: 5, npre: 7, rpat: 8'hFF, exp_count: 5, exp_left: 2};

    rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset m_valid", int'(m_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset count", int'(count), 0);
    chk("reset fifo_r_en", int'(fifo_r_en), 0);
    chk("reset m_data", int'(m_data), 0);
    rst = 1'b0;

    // Basic latency and back-to-back throughput.
    clear_log();
    m_ready = 1'b1;
    preload(4, 'h11, 'h11);
    do_start(4);
    wait_done("A", 1'b0, 8'h00);
    chk("A reads", nrd(), 4);
    chk("A first read edge", rd_at(0), e0 + 1);
    chk("A last read edge", rd_at(3), e0 + 4);
    chk("A handshakes", nhs(), 4);
    chk("A first hs edge", hsc_at(0), e0 + 3);
    chk("A last hs edge", hsc_at(3), e0 + 6);
    for (int i = 0; i < 4; i++) chk($sformatf("A data%0d", i), hsd_at(i), 'h11 * (i + 1));
    chk("A done edge", dn_at(0), e0 + 7);
    chk("A count", int'(count), 4);
    chk("A busy after", int'(busy), 0);

    // Backpressure: two reads in flight, head held stable.
    clear_log();
    m_ready = 1'b0;
    preload(4, 'h11, 'h11);
    do_start(4);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_valid && m_data !== 8'h11) stable = 1'b0;
    end
    chk("B reads under stall", nrd(), 2);
    chk("B r_en idle", int'(fifo_r_en), 0);
    chk("B m_valid", int'(m_valid), 1);
    chk("B head", int'(m_data), 'h11);
    chk("B head stable", int'(stable), 1);
    m_ready = 1'b1;
    wait_done("B", 1'b0, 8'h00);
    chk("B handshakes", nhs(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("B data%0d", i), hsd_at(i), 'h11 * (i + 1));
    chk("B count", int'(count), 4);

    // Empty FIFO stalls the burst until more bytes are written.
    clear_log();
    preload(1, 'hA1, 1);
    do_start(3);
    repeat (5) @(negedge clk);
    chk("C reads while empty", nrd(), 1);
    chk("C r_en while empty", int'(fifo_r_en), 0);
    chk("C busy while empty", int'(busy), 1);
    preload(2, 'hA2, 1);
    wait_done("C", 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("C data%0d", i), hsd_at(i), 'hA1 + i);
    chk("C done pulses", ndn(), 1);
    chk("C count", int'(count), 3);

    // Zero-length burst.
    clear_log();
    do_start(0);
    chk("D busy", int'(busy), 1);
    chk("D done", int'(done), 1);
    chk("D count", int'(count), 0);
    @(negedge clk);
    chk("D busy after", int'(busy), 0);
    chk("D done after", int'(done), 0);
    chk("D reads", nrd(), 0);

    // Reset in the middle of a burst, then a fresh burst.
    clear_log();
    preload(5, 'h51, 1);
    do_start(5);
    n = 0;
    while (nhs() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("E hs before reset", nhs(), 2);
    rst = 1'b1;
    flush_fifo();
    @(negedge clk);
    rst = 1'b0;
    chk("E m_valid", int'(m_valid), 0);
    chk("E busy", int'(busy), 0);
    chk("E count", int'(count), 0);
    chk("E r_en", int'(fifo_r_en), 0);
    clear_log();
    preload(2, 'h61, 1);
    do_start(2);
    wait_done("E", 1'b0, 8'h00);
    chk("E new data0", hsd_at(0), 'h61);
    chk("E new data1", hsd_at(1), 'h62);
    chk("E new count", int'(count), 2);

    // Start during a burst is ignored.
    clear_log();
    preload(6, 'hC1, 1);
    do_start(4);
    @(negedge clk);
    start = 1'b1;
    len   = LW'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done("F", 1'b0, 8'h00);
    repeat (6) @(negedge clk);
    chk("F count", int'(count), 4);
    chk("F done pulses", ndn(), 1);
    chk("F handshakes", nhs(), 4);
    chk("F reads", nrd(), 4);
    chk("F busy", int'(busy), 0);
    flush_fifo();

    // Table-driven bursts with varied ready patterns.
    for (int v = 0; v < 5; v++) begin
      clear_log();
      m_ready = 1'b0;
      base = 16 * (v + 1);
      preload(vecs[v].npre, base, 1);
      do_start(vecs[v].len);
      wait_done($sformatf("T%0d", v), 1'b1, vecs[v].rpat);
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk($sformatf("T%0d count", v), int'(count), vecs[v].exp_count);
      chk($sformatf("T%0d handshakes", v), nhs(), vecs[v].exp_count);
      for (int i = 0; i < vecs[v].exp_count; i++)
        chk($sformatf("T%0d data%0d", v, i), hsd_at(i), base + i);
      chk($sformatf("T%0d done pulses", v), ndn(), 1);
      chk($sformatf("T%0d fifo left", v), wr_ptr - rd_ptr, vecs[v].exp_left);
      chk($sformatf("T%0d busy", v), int'(busy), 0);
      flush_fifo();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
